gsim_seq: RTL
=============

# gsim_seq

Control sequencer for the Gauss-Seidel iteration machine. It owns the schedule for a single shared multiply-accumulate datapath: it loads the 16 right-hand-side values, seeds the solution registers, and walks the banded 16x16 matrix row by row for a fixed number of sweeps. It then streams the 16 results out under a valid/ready handshake. It holds no arithmetic data: it drives only strobes and addresses into the datapath register files and MAC.

## Interface
- N, 16: system order; row, col and address ports are 4 bits wide.
- BAND, 3: half bandwidth; A[k][j] is non-zero only for |j-k| <= BAND.
- ITER, 120: number of full sweeps, range 1..255.
- MAC_LAT, 2: cycles from the last mac_en of a row to a stable accumulator, range 1..7.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_en  input  1  b_in sample valid; the datapath captures b_in on load_we.
- out_ready  input  1  downstream accepts x_out.
- load_we  output  1  write B[load_addr].
- load_addr  output  4  B index being loaded.
- init_we  output  1  seed X[row] = B[row]/A[row][row].
- mac_clr  output  1  load the accumulator instead of adding; asserted with the first mac_en of a row.
- mac_en  output  1  accumulate A[row][col]*X[col].
- wb_en  output  1  write X[row] = (B[row] - acc)/A[row][row].
- row  output  4  current row index.
- col  output  4  current column index.
- rd_addr  output  4  X index presented on x_out.
- out_valid  output  1  x_out valid.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last result is accepted.

## Operation
- States: IDLE, LOAD, INIT, ROW, DRAIN, WB, OUT.
- **IDLE**
  - in_en=1 produces load_we=1, load_addr=0, cnt=1, and moves to LOAD.
  - All other inputs are ignored.
- **LOAD**
  - Each in_en cycle produces load_we=1 with load_addr=cnt, then cnt increments.
  - Gaps in in_en are allowed; load_we follows in_en.
  - After sample 15 is written, move to INIT.
- **INIT**
  - init_we=1 for N consecutive cycles, with row=0..N-1.
  - Then move to ROW with iter=0 and row=0.
- **ROW**
  - Issue one mac_en per cycle for col = max(0,row-BAND) .. min(N-1,row+BAND), ascending, skipping col==row.
  - mac_clr is high on the first of these cycles only.
  - After the last column, move to DRAIN.
- **DRAIN**: MAC_LAT cycles with all strobes low, then move to WB.
- **WB**
  - One cycle with wb_en=1 and row held.
  - Next row: return to ROW.
  - After row N-1: increment iter, set row=0, and go to ROW; after the last sweep (iter==ITER-1), go to OUT instead.
- **OUT**
  - out_valid=1, rd_addr=ocnt.
  - On out_valid & out_ready, ocnt increments.
  - When accept number N (ocnt==N-1) completes, pulse done and go to IDLE.
  - While out_ready=0, rd_addr and out_valid hold.
- Non-zeros issued per row, with N=16 and BAND=3: 3,4,5, then 6 for rows 3..12, then 5,4,3. Total 84 per sweep.
- Counters
  - cnt and ocnt are 4 bits and never wrap past N-1.
  - iter is 8 bits.
- Strobe exclusivity: load_we, init_we, mac_en and wb_en are mutually exclusive in every cycle.

## Timing
- **Reset**
  - reset low forces, asynchronously: state=IDLE, all counters 0, and every output 0. This includes row, col, rd_addr, busy and done.
  - Reset mid-operation abandons the run.
  - The first in_en after reset release starts a new load at address 0.
- **Row cost**: non-zero count + MAC_LAT + 1 cycles. With defaults, a sweep is 84 + 48 = 132 cycles.
- **Latency** from the 16th load_we to the first out_valid: N + ITER*132 cycles (defaults: 16 + 15840).
- **Registered outputs**: all outputs come from registers. Strobes appear in the cycle of the state or index they label, with row and col valid in that same cycle.
- **in_en** is ignored in INIT, ROW, DRAIN, WB and OUT. No sample is captured and no counter changes.
- **done** is high exactly one cycle: the first IDLE cycle after the final handshake. busy is low in that cycle.
- **Output handshake**: x_out must be valid the cycle after rd_addr changes. The datapath uses a combinational read, so out_valid may assert in the first OUT cycle.

## Test plan
- **Reset and load**
  - Stimulus: assert reset low mid-LOAD (cnt=7), release, then send 16 in_en samples with 3 idle gaps.
  - Required: all outputs are 0 during reset; load_we fires 16 times with load_addr 0..15; INIT begins the cycle after the 16th write.
- **Row 0 schedule** (ITER=1)
  - Required: mac_en cols 1,2,3, with mac_clr on col 1; 2 DRAIN cycles; wb_en with row=0.
  - Required: row 5 issues cols 2,3,4,6,7,8.
- **Sweep count** (ITER=2)
  - Required: exactly 168 mac_en and 32 wb_en pulses.
  - Required: first out_valid arrives 16 + 264 cycles after the last load_we.
- **Output backpressure**
  - Stimulus: toggle out_ready 1,0,0,1 repeatedly.
  - Required: rd_addr steps 0..15 only on accepted cycles; rd_addr and out_valid are stable during stalls; done pulses once; busy drops with done.
- **Ignored input**
  - Stimulus: pulse in_en during ROW and OUT.
  - Required: no load_we and no schedule change.
- **Back-to-back runs**
  - Stimulus: start a second load in the cycle after done.
  - Required: load_addr restarts at 0 and the second run repeats the identical strobe trace.

Source files
------------

// File: rtl/gsim_seq.sv
// gsim_seq: schedule sequencer for the Gauss-Seidel MAC datapath.
// Drives load, seed, MAC and write-back strobes; streams results out.
module gsim_seq #(
    parameter int N       = 16,
    parameter int BAND    = 3,
    parameter int ITER    = 120,
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en,
    input  logic       out_ready,
    output logic       load_we,
    output logic [3:0] load_addr,
    output logic       init_we,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       wb_en,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] rd_addr,
    output logic       out_valid,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] INIT  = 3'd2;
    localparam logic [2:0] ROW   = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] WB    = 3'd5;
    localparam logic [2:0] OUT   = 3'd6;

    localparam logic [3:0] B4   = 4'(BAND);
    localparam logic [3:0] L4   = 4'(N - 1);
    localparam logic [2:0] DEND = 3'(MAC_LAT - 1);
    localparam logic [7:0] IEND = 8'(ITER - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic [3:0] rrow;
    logic [3:0] ccol;
    logic       first;
    logic [2:0] dcnt;
    logic [7:0] iter;

    // First in-band column of a row, stepping over the diagonal.
    function automatic logic [3:0] col_lo(input logic [3:0] r);
        logic [3:0] v;
        v = (r > B4) ? r - B4 : 4'd0;
        if (v == r) v = v + 4'd1;
        return v;
    endfunction

    // Last in-band column of a row, stepping back over the diagonal.
    function automatic logic [3:0] col_hi(input logic [3:0] r);
        logic [4:0] s;
        logic [3:0] v;
        s = {1'b0, r} + {1'b0, B4};
        v = (s > {1'b0, L4}) ? L4 : s[3:0];
        if (v == r) v = v - 4'd1;
        return v;
    endfunction

    // Column after c within row r, skipping the diagonal.
    function automatic logic [3:0] col_nx(input logic [3:0] c,
                                          input logic [3:0] r);
        logic [3:0] v;
        v = c + 4'd1;
        if (v == r) v = v + 4'd1;
        return v;
    endfunction

    // Phase sequencer: each edge registers the strobes for the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rrow      <= '0;
            ccol      <= '0;
            first     <= 1'b0;
            dcnt      <= '0;
            iter      <= '0;
            load_we   <= 1'b0;
            load_addr <= '0;
            init_we   <= 1'b0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            wb_en     <= 1'b0;
            row       <= '0;
            col       <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            load_we <= 1'b0;
            init_we <= 1'b0;
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            wb_en   <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_en) begin
                        load_we   <= 1'b1;
                        load_addr <= '0;
                        cnt       <= 4'd1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_en) begin
                        load_we   <= 1'b1;
                        load_addr <= cnt;
                        if (cnt == L4) begin
                            rrow  <= '0;
                            state <= INIT;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                INIT: begin
                    init_we <= 1'b1;
                    row     <= rrow;
                    if (rrow == L4) begin
                        rrow  <= '0;
                        iter  <= '0;
                        ccol  <= col_lo(4'd0);
                        first <= 1'b1;
                        state <= ROW;
                    end else begin
                        rrow <= rrow + 4'd1;
                    end
                end
                ROW: begin
                    mac_en  <= 1'b1;
                    mac_clr <= first;
                    first   <= 1'b0;
                    row     <= rrow;
                    col     <= ccol;
                    if (ccol == col_hi(rrow)) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        ccol <= col_nx(ccol, rrow);
                    end
                end
                DRAIN: begin
                    if (dcnt == DEND) state <= WB;
                    else dcnt <= dcnt + 3'd1;
                end
                WB: begin
                    wb_en <= 1'b1;
                    row   <= rrow;
                    first <= 1'b1;
                    if (rrow == L4) begin
                        rrow <= '0;
                        ccol <= col_lo(4'd0);
                        if (iter == IEND) begin
                            state <= OUT;
                        end else begin
                            iter  <= iter + 8'd1;
                            state <= ROW;
                        end
                    end else begin
                        rrow  <= rrow + 4'd1;
                        ccol  <= col_lo(rrow + 4'd1);
                        state <= ROW;
                    end
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        rd_addr   <= '0;
                    end else if (out_ready) begin
                        if (rd_addr == L4) begin
                            out_valid <= 1'b0;
                            rd_addr   <= '0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rd_addr <= rd_addr + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
